// File: rtl/sprite_pkg.sv
// sprite_pkg: shared address map, field/state encodings and decode helper
// for the sprite attribute table.
package sprite_pkg;

  localparam logic [3:0]  SPR_REGION          = 4'h1;
  localparam logic [15:0] SPR_CTRL_ADDR       = 16'h2000;
  localparam int unsigned CTRL_COMMIT_BIT     = 0;
  localparam int unsigned CTRL_CLEAR_DROP_BIT = 1;

  typedef enum logic [1:0] {
    FIELD_X     = 2'd0,
    FIELD_Y     = 2'd1,
    FIELD_TILE  = 2'd2,
    FIELD_FLAGS = 2'd3
  } field_e;

  typedef enum logic {
    IDLE = 1'b0,
    COPY = 1'b1
  } state_e;

  // True when addr falls in the sprite window with all bits above the
  // sprite index clear.
  function automatic logic is_sprite_addr(input logic [15:0] addr,
                                          input int unsigned idx_w);
    logic [11:0] upper;
    upper = addr[11:0] >> (2 + idx_w);
    return (addr[15:12] == SPR_REGION) && (upper == '0);
  endfunction

endpackage

// File: rtl/sprite_bank.sv
// sprite_bank: 4*NUM_SPRITES x 16 register array, async-cleared, with one
// write port, one combinational read port and one registered read port.
module sprite_bank #(
  parameter  int unsigned NUM_SPRITES = 8,
  localparam int unsigned AW          = $clog2(NUM_SPRITES) + 2,
  localparam int unsigned DEPTH       = 4 * NUM_SPRITES
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic [AW-1:0] comb_addr,
  output logic [15:0]   comb_data,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data
);

  logic [15:0] mem [DEPTH];

  // Storage array: cleared on reset, single write port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign comb_data = mem[comb_addr];

  // Registered read port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sprite_table.sv
// sprite_table: memory-write responder feeding a sprite attribute table.
// Build option SPRITE_DOUBLE_BUFFER_EN: CPU writes go to a shadow bank that
// is copied to the active bank during vblank after a commit request.
// Without it, writes go straight to the active bank.
import sprite_pkg::*;

module sprite_table #(
  parameter  int unsigned NUM_SPRITES = 8,
  localparam int unsigned IDX_W       = $clog2(NUM_SPRITES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             write,
  input  logic [15:0]      wr_addr,
  input  logic [15:0]      wr_data,
  input  logic             vblank,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [1:0]       rd_field,
  output logic [15:0]      rd_data,
  output logic             commit_pending,
  output logic             busy,
  output logic             dropped,
  output logic [7:0]       commit_count
);

  localparam int unsigned AW    = IDX_W + 2;
  localparam int unsigned WORDS = 4 * NUM_SPRITES;

  field_e          wr_field;
  logic [AW-1:0]   wr_word;
  logic [AW-1:0]   rd_word;
  logic            spr_hit;
  logic [15:0]     unused_active_comb;

  assign wr_field = field_e'(wr_addr[1:0]);
  assign wr_word  = {wr_addr[IDX_W+1:2], wr_field};
  assign rd_word  = {rd_index, rd_field};
  assign spr_hit  = write && is_sprite_addr(wr_addr, IDX_W);

`ifdef SPRITE_DOUBLE_BUFFER_EN

  state_e          state;
  state_e          state_next;
  logic [AW-1:0]   k;
  logic            copy_last;
  logic            copy_start;
  logic            ctrl_hit;
  logic [15:0]     shadow_word;
  logic [15:0]     unused_shadow_rd;

  assign ctrl_hit  = write && (wr_addr == SPR_CTRL_ADDR);
  assign copy_last = (k == AW'(WORDS - 1));

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: start on vblank with a registered pending commit, finish
  // after the last word.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (vblank && commit_pending) state_next = COPY;
      COPY:    if (copy_last)                state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy       = (state == COPY);
    copy_start = (state == IDLE) && vblank && commit_pending;
  end

  // Copy counter, commit/drop flags and completed-copy counter.
  // A commit request arriving on the cycle a copy starts survives as a new
  // pending request rather than being absorbed by the starting copy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      k              <= '0;
      commit_pending <= 1'b0;
      dropped        <= 1'b0;
      commit_count   <= '0;
    end else begin
      if (copy_start) begin
        k <= '0;
      end else if (busy) begin
        k <= k + 1'b1;
      end

      if (ctrl_hit && wr_data[CTRL_COMMIT_BIT]) begin
        commit_pending <= 1'b1;
      end else if (copy_start) begin
        commit_pending <= 1'b0;
      end

      if (spr_hit && busy) begin
        dropped <= 1'b1;
      end else if (ctrl_hit && wr_data[CTRL_CLEAR_DROP_BIT]) begin
        dropped <= 1'b0;
      end

      if (busy && copy_last) begin
        commit_count <= commit_count + 8'd1;
      end
    end
  end

  sprite_bank #(.NUM_SPRITES(NUM_SPRITES)) u_shadow (
    .clock     (clock),
    .reset     (reset),
    .we        (spr_hit && !busy),
    .wr_addr   (wr_word),
    .wr_data   (wr_data),
    .comb_addr (k),
    .comb_data (shadow_word),
    .rd_addr   (rd_word),
    .rd_data   (unused_shadow_rd)
  );

  sprite_bank #(.NUM_SPRITES(NUM_SPRITES)) u_active (
    .clock     (clock),
    .reset     (reset),
    .we        (busy),
    .wr_addr   (k),
    .wr_data   (shadow_word),
    .comb_addr (AW'(0)),
    .comb_data (unused_active_comb),
    .rd_addr   (rd_word),
    .rd_data   (rd_data)
  );

`else

  assign commit_pending = 1'b0;
  assign busy           = 1'b0;
  assign dropped        = 1'b0;

  // Frame counter: one step per vblank.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      commit_count <= '0;
    end else if (vblank) begin
      commit_count <= commit_count + 8'd1;
    end
  end

  sprite_bank #(.NUM_SPRITES(NUM_SPRITES)) u_active (
    .clock     (clock),
    .reset     (reset),
    .we        (spr_hit),
    .wr_addr   (wr_word),
    .wr_data   (wr_data),
    .comb_addr (AW'(0)),
    .comb_data (unused_active_comb),
    .rd_addr   (rd_word),
    .rd_data   (rd_data)
  );

`endif

endmodule

// File: tb/tb_sprite_table.sv
// tb_sprite_table: directed stimulus against a word-level model of the
// sprite table, plus literal expectations. Follows SPRITE_DOUBLE_BUFFER_EN.
module tb_sprite_table;

  localparam int NS    = 8;
  localparam int IDX_W = 3;
  localparam int WORDS = 4 * NS;
`ifdef SPRITE_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             write = 1'b0;
  logic [15:0]      wr_addr = '0;
  logic [15:0]      wr_data = '0;
  logic             vblank = 1'b0;
  logic [IDX_W-1:0] rd_index = '0;
  logic [1:0]       rd_field = '0;
  logic [15:0]      rd_data;
  logic             commit_pending;
  logic             busy;
  logic             dropped;
  logic [7:0]       commit_count;

  int n_cmp = 0;
  int n_bad = 0;

  sprite_table #(.NUM_SPRITES(NS)) dut (
    .clock          (clock),
    .reset          (reset),
    .write          (write),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .vblank         (vblank),
    .rd_index       (rd_index),
    .rd_field       (rd_field),
    .rd_data        (rd_data),
    .commit_pending (commit_pending),
    .busy           (busy),
    .dropped        (dropped),
    .commit_count   (commit_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [15:0] m_shadow [WORDS];
  logic [15:0] m_active [WORDS];
  logic        m_busy = 1'b0;
  logic        m_pending = 1'b0;
  logic        m_dropped = 1'b0;
  logic [7:0]  m_count = '0;
  logic [15:0] m_rd = '0;
  int          m_pos = 0;

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) begin
        m_shadow[i] = '0;
        m_active[i] = '0;
      end
      m_busy = 0; m_pending = 0; m_dropped = 0; m_count = 0; m_rd = 0; m_pos = 0;
    end else begin : step
      bit spr, ctrl, was_busy;
      int w;
      spr  = write && (wr_addr[15:12] == 4'h1) && ((wr_addr[11:0] >> (2 + IDX_W)) == 0);
      ctrl = write && (wr_addr == 16'h2000);
      w    = int'(wr_addr[IDX_W+1:0]);
      m_rd = m_active[int'(rd_index) * 4 + int'(rd_field)];
      if (DB) begin
        was_busy = m_busy;
        if (m_busy) begin
          m_active[m_pos] = m_shadow[m_pos];
          m_pos++;
          if (m_pos == WORDS) begin
            m_busy = 0;
            m_count = m_count + 8'd1;
          end
        end else if (vblank && m_pending) begin
          m_busy = 1; m_pos = 0; m_pending = 0;
        end
        if (spr) begin
          if (was_busy) m_dropped = 1;
          else          m_shadow[w] = wr_data;
        end
        if (ctrl) begin
          if (wr_data[0]) m_pending = 1;
          if (wr_data[1]) m_dropped = 0;
        end
      end else begin
        if (spr)    m_active[w] = wr_data;
        if (vblank) m_count = m_count + 8'd1;
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clock) begin
    check("rd_data", rd_data, m_rd);
    check("busy", {15'd0, busy}, {15'd0, m_busy});
    check("commit_pending", {15'd0, commit_pending}, {15'd0, m_pending});
    check("dropped", {15'd0, dropped}, {15'd0, m_dropped});
    check("commit_count", {8'd0, commit_count}, {8'd0, m_count});
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    write = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic pulse_vblank();
    vblank = 1'b1;
    @(negedge clock);
    vblank = 1'b0;
  endtask

  task automatic read_word(input int idx, input int f);
    rd_index = IDX_W'(idx);
    rd_field = 2'(f);
    @(negedge clock);
  endtask

  task automatic wait_not_busy(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      @(negedge clock);
      cycles++;
    end
    check("copy_done", {15'd0, busy}, 16'd0);
  endtask

  int ncyc;

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("reset_rd", rd_data, 16'h0000);
    check("reset_count", {8'd0, commit_count}, 16'd0);

    // Write without commit: active bank untouched when double-buffered.
    do_write(16'h1004, 16'h0055);
    read_word(1, 0);
    check("nocommit_rd", rd_data, DB ? 16'h0000 : 16'h0055);

    // Commit, then vblank: 32-cycle copy.
    do_write(16'h2000, 16'h0001);
    check("pending_set", {15'd0, commit_pending}, DB ? 16'd1 : 16'd0);
    pulse_vblank();
    wait_not_busy(ncyc);
    check("busy_cycles", 16'(ncyc), DB ? 16'd32 : 16'd0);
    read_word(1, 0);
    check("commit_rd", rd_data, 16'h0055);
    check("count1", {8'd0, commit_count}, 16'd1);
    check("pending_clr", {15'd0, commit_pending}, 16'd0);

    // Second copy: drop a write and request a commit mid-copy.
    do_write(16'h2000, 16'h0001);
    pulse_vblank();
    repeat (3) @(negedge clock);
    do_write(16'h1008, 16'h1234);
    check("dropped_set", {15'd0, dropped}, DB ? 16'd1 : 16'd0);
    do_write(16'h2000, 16'h0001);
    wait_not_busy(ncyc);
    check("pending_after", {15'd0, commit_pending}, DB ? 16'd1 : 16'd0);
    check("count2", {8'd0, commit_count}, 16'd2);
    do_write(16'h2000, 16'h0002);
    check("dropped_clr", {15'd0, dropped}, 16'd0);
    pulse_vblank();
    wait_not_busy(ncyc);
    check("count3", {8'd0, commit_count}, 16'd3);
    read_word(2, 0);
    check("dropped_rd", rd_data, DB ? 16'h0000 : 16'h1234);

    // Sprite write on the vblank cycle that starts a copy.
    do_write(16'h2000, 16'h0001);
    write = 1'b1; wr_addr = 16'h1000; wr_data = 16'hAAAA; vblank = 1'b1;
    @(negedge clock);
    write = 1'b0; vblank = 1'b0;
    wait_not_busy(ncyc);
    read_word(0, 0);
    check("samecyc_rd", rd_data, 16'hAAAA);
    check("count4", {8'd0, commit_count}, 16'd4);

    // Commit request on a vblank with nothing pending: no copy this frame.
    write = 1'b1; wr_addr = 16'h2000; wr_data = 16'h0001; vblank = 1'b1;
    @(negedge clock);
    write = 1'b0; vblank = 1'b0;
    check("nocopy_busy", {15'd0, busy}, 16'd0);
    check("nocopy_pending", {15'd0, commit_pending}, DB ? 16'd1 : 16'd0);
    repeat (2) @(negedge clock);
    check("nocopy_busy2", {15'd0, busy}, 16'd0);

    // Addresses outside the map have no effect.
    do_write(16'h1100, 16'hFFFF);
    do_write(16'h3000, 16'hFFFF);
    do_write(16'h0000, 16'hFFFF);
    check("ignored_dropped", {15'd0, dropped}, 16'd0);
    pulse_vblank();
    wait_not_busy(ncyc);
    read_word(0, 0);
    check("ignored_rd", rd_data, 16'hAAAA);
    check("count5", {8'd0, commit_count}, DB ? 16'd5 : 16'd6);

    // Reset at cycle 10 of a copy.
    do_write(16'h1004, 16'hBEEF);
    do_write(16'h2000, 16'h0001);
    pulse_vblank();
    repeat (9) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst_rd", rd_data, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_pending", {15'd0, commit_pending}, 16'd0);
    check("rst_dropped", {15'd0, dropped}, 16'd0);
    check("rst_count", {8'd0, commit_count}, 16'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < NS; i++) begin
      for (int f = 0; f < 4; f++) begin
        read_word(i, f);
        check("rst_word", rd_data, 16'h0000);
      end
    end
    check("rst_noresume", {15'd0, busy}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
